// File: rtl/cordic_job_arbiter.sv
// cordic_job_arbiter: round-robin arbiter sharing one CORDIC engine among
// NREQ requesters. One job in flight: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Optional watchdog on the WAIT phase enabled by defining CORDIC_ARB_TIMEOUT_EN;
// without it rsp_err is tied low and WAIT lasts until eng_done.
module cordic_job_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 16,
  parameter int TIMEOUT = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_angle,
  output logic [NREQ-1:0]      req_ready,
  output logic                 eng_start,
  output logic [DW-1:0]        eng_angle,
  input  logic                 eng_done,
  input  logic [DW-1:0]        eng_x,
  input  logic [DW-1:0]        eng_y,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [DW-1:0]        rsp_x,
  output logic [DW-1:0]        rsp_y,
  output logic                 rsp_err,
  output logic                 busy
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   last_q, last_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [DW-1:0]   angle_q, angle_d;
  logic [DW-1:0]   rx_q, rx_d;
  logic [DW-1:0]   ry_q, ry_d;
  logic [GW-1:0]   arb_idx;
  logic            arb_hit;

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0]   wdog_q, wdog_d;
  logic            err_q, err_d;
`else
  // Keeps TIMEOUT referenced in builds without the watchdog.
  logic [31:0]     unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
`endif

  // Round-robin pick: first valid requester after last_grant, wrapping.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!arb_hit && req_valid[(int'(last_q) + k) % NREQ]) begin
        arb_hit = 1'b1;
        arb_idx = GW'((int'(last_q) + k) % NREQ);
      end
    end
  end

  assign req_ready = (state_q == S_IDLE && arb_hit) ? (NREQ'(1) << arb_idx) : '0;
  assign rsp_valid = (state_q == S_RESP) ? (NREQ'(1) << gnt_q) : '0;
  assign eng_start = (state_q == S_ISSUE);
  assign eng_angle = angle_q;
  assign rsp_x     = rx_q;
  assign rsp_y     = ry_q;
  assign busy      = (state_q != S_IDLE);
`ifdef CORDIC_ARB_TIMEOUT_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif

  // Next-state and datapath capture for the single in-flight job.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    angle_d = angle_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
`ifdef CORDIC_ARB_TIMEOUT_EN
    wdog_d  = wdog_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        // req_ready is only raised for a valid requester, so a hit is a transfer.
        if (arb_hit) begin
          gnt_d   = arb_idx;
          angle_d = req_angle[int'(arb_idx)*DW +: DW];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef CORDIC_ARB_TIMEOUT_EN
        wdog_d  = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion wins over a timeout landing on the same cycle.
        if (eng_done) begin
          rx_d    = eng_x;
          ry_d    = eng_y;
`ifdef CORDIC_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = S_RESP;
        end
`ifdef CORDIC_ARB_TIMEOUT_EN
        else if (wdog_q == WW'(TIMEOUT - 1)) begin
          rx_d    = '0;
          ry_d    = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          wdog_d  = wdog_q + WW'(1);
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready[gnt_q]) begin
          last_d  = gnt_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and job registers; reset leaves requester 0 first in line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= GW'(NREQ - 1);
      gnt_q   <= '0;
      angle_q <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
      wdog_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      angle_q <= angle_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
`ifdef CORDIC_ARB_TIMEOUT_EN
      wdog_q  <= wdog_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule
